// File: rtl/level_to_pulse.sv
// Turns a selected edge on an asynchronous level into one PULSE_WIDTH-cycle pulse, followed by HOLDOFF dead cycles.
// Latency: o_Pulse rises 2 clocks after the edge lands in the synchroniser, plus up to 1 clock of sampling uncertainty.
// No backpressure: an edge that arrives while busy is dropped and flagged on o_Drop, never queued.
module level_to_pulse #(
    parameter int PULSE_WIDTH = 4,
    parameter int HOLDOFF     = 8,
    parameter int EDGE_MODE   = 0,
    parameter int CNT_W       = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Level,
    input  logic             i_En,
    output logic             o_Pulse,
    output logic             o_Busy,
    output logic             o_Drop,
    output logic [CNT_W-1:0] o_Pulse_Cnt
);

    // Encoding is {busy, pulse} so both outputs come straight off state flops.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HOLD  = 2'b10,
        PULSE = 2'b11
    } state_t;

    localparam logic [7:0] PW_LOAD  = 8'(PULSE_WIDTH - 1);
    localparam bit         HAS_HOLD = (HOLDOFF > 0);
    localparam logic [7:0] HO_LOAD  = HAS_HOLD ? 8'(HOLDOFF - 1) : 8'd0;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       tmr;
    logic [7:0]       tmr_nxt;
    logic             launch;
    logic             drop_nxt;
    logic             drop_q;
    logic [CNT_W-1:0] pulse_cnt;

    logic       sync1;
    logic       sync2;
    logic       prev;
    logic [1:0] arm_cnt;
    logic       arm;
    logic       rise;
    logic       fall;
    logic       sel_edge;
    logic       qual;

    // Arm only once sync2 and prev both hold post-reset samples, so a level
    // already high at release never looks like an edge.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            prev    <= 1'b0;
            arm_cnt <= 2'd0;
            arm     <= 1'b0;
        end else begin
            sync1 <= i_Level;
            sync2 <= sync1;
            prev  <= sync2;
            if (!arm) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
            arm <= arm | (arm_cnt == 2'd2);
        end
    end

    assign rise     = sync2 & ~prev;
    assign fall     = ~sync2 & prev;
    assign sel_edge = (EDGE_MODE == 0) ? rise :
                      (EDGE_MODE == 1) ? fall : (rise | fall);
    assign qual     = arm & sel_edge;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state     <= IDLE;
            tmr       <= 8'd0;
            drop_q    <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            state  <= state_nxt;
            tmr    <= tmr_nxt;
            drop_q <= drop_nxt;
            if (launch) begin
                pulse_cnt <= pulse_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        launch    = 1'b0;
        drop_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (qual && i_En) begin
                    state_nxt = PULSE;
                    tmr_nxt   = PW_LOAD;
                    launch    = 1'b1;
                end
            end
            PULSE: begin
                drop_nxt = qual & i_En;
                if (tmr == 8'd0) begin
                    state_nxt = HAS_HOLD ? HOLD : IDLE;
                    tmr_nxt   = HO_LOAD;
                end else begin
                    tmr_nxt = tmr - 8'd1;
                end
            end
            HOLD: begin
                drop_nxt = qual & i_En;
                if (tmr == 8'd0) begin
                    state_nxt = IDLE;
                end else begin
                    tmr_nxt = tmr - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tmr_nxt   = 8'd0;
            end
        endcase
    end

    always_comb begin
        o_Pulse     = state[0];
        o_Busy      = state[1];
        o_Drop      = drop_q;
        o_Pulse_Cnt = pulse_cnt;
    end

endmodule

// File: tb/tb_level_to_pulse.sv
// Directed bench for level_to_pulse: three instances (defaults, both-edge 1/0, falling-edge 1/0 with 2-bit counter).
// Expected pulse starts and drop cycles are queued at stimulus time and matched by a negedge monitor.
module tb_level_to_pulse;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b1;
    logic lvl0  = 1'b1;
    logic lvl1  = 1'b1;
    logic lvl2  = 1'b1;

    logic p0, p1, p2, b0, b1, b2, d0, d1, d2;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [1:0] cnt2;
    logic [2:0] pul, bsy, drp;

    int   cyc   = 0;
    logic rst_q = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int exp_p [3][$];
    int exp_d [3][$];
    int start_c [3];
    bit act [3];
    int pw [3] = '{4, 1, 1};

    assign pul = {p2, p1, p0};
    assign bsy = {b2, b1, b0};
    assign drp = {d2, d1, d0};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    level_to_pulse u0 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Level(lvl0), .i_En(en),
        .o_Pulse(p0), .o_Busy(b0), .o_Drop(d0), .o_Pulse_Cnt(cnt0)
    );

    level_to_pulse #(.PULSE_WIDTH(1), .HOLDOFF(0), .EDGE_MODE(2), .CNT_W(8)) u1 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Level(lvl1), .i_En(en),
        .o_Pulse(p1), .o_Busy(b1), .o_Drop(d1), .o_Pulse_Cnt(cnt1)
    );

    level_to_pulse #(.PULSE_WIDTH(1), .HOLDOFF(0), .EDGE_MODE(1), .CNT_W(2)) u2 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Level(lvl2), .i_En(en),
        .o_Pulse(p2), .o_Busy(b2), .o_Drop(d2), .o_Pulse_Cnt(cnt2)
    );

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every pulse rise and drop cycle must match a queued expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_q) begin
                act[i] = 1'b0;
            end else begin
                if (pul[i] && !act[i]) begin
                    act[i]     = 1'b1;
                    start_c[i] = cyc;
                    check($sformatf("pulse_expected%0d", i), int'(exp_p[i].size() > 0), 1);
                    if (exp_p[i].size() > 0)
                        check($sformatf("pulse_start%0d", i), cyc, exp_p[i].pop_front());
                end else if (!pul[i] && act[i]) begin
                    act[i] = 1'b0;
                    check($sformatf("pulse_width%0d", i), cyc - start_c[i], pw[i]);
                end
                if (drp[i]) begin
                    check($sformatf("drop_expected%0d", i), int'(exp_d[i].size() > 0), 1);
                    if (exp_d[i].size() > 0)
                        check($sformatf("drop_cycle%0d", i), cyc, exp_d[i].pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        step(3);
        check("rst_pulse", int'(pul[0]), 0);
        check("rst_busy", int'(bsy[0]), 0);
        check("rst_drop", int'(drp[0]), 0);
        check("rst_cnt", int'(cnt0), 0);

        // Level high across reset release must never launch.
        rst_n = 1'b1;
        step(20);
        check("hi_release_cnt0", int'(cnt0), 0);
        check("hi_release_cnt1", int'(cnt1), 0);
        check("hi_release_pulse", int'(pul[0]), 0);
        lvl0 = 1'b0;
        step(4);

        // First pulse, dropped retrigger in HOLD, re-accept after busy falls.
        t = cyc;
        lvl0 = 1'b1; exp_p[0].push_back(t + 3);
        step(3);
        check("first_pulse_hi", int'(pul[0]), 1);
        check("first_cnt", int'(cnt0), 1);
        lvl0 = 1'b0;
        step(3);
        lvl0 = 1'b1; exp_d[0].push_back(t + 9);
        step(4);
        check("cnt_after_drop", int'(cnt0), 1);
        lvl0 = 1'b0;
        step(4);
        check("busy_last_cycle", int'(bsy[0]), 1);
        step(1);
        check("busy_released", int'(bsy[0]), 0);
        lvl0 = 1'b1; exp_p[0].push_back(t + 18);
        step(3);
        check("third_cnt", int'(cnt0), 2);
        step(12);

        // Edge landing in the final HOLD cycle is dropped, not queued.
        lvl0 = 1'b0;
        step(4);
        t = cyc;
        lvl0 = 1'b1; exp_p[0].push_back(t + 3);
        step(3);
        lvl0 = 1'b0;
        step(9);
        lvl0 = 1'b1; exp_d[0].push_back(t + 15);
        step(3);
        check("busy_after_final_drop", int'(bsy[0]), 0);
        step(10);
        check("cnt_final_hold", int'(cnt0), 3);

        // Enable low at the edge, then enable dropped mid-pulse.
        lvl0 = 1'b0;
        step(4);
        en = 1'b0; lvl0 = 1'b1;
        step(6);
        check("en_off_cnt", int'(cnt0), 3);
        en = 1'b1; lvl0 = 1'b0;
        step(4);
        t = cyc;
        lvl0 = 1'b1; exp_p[0].push_back(t + 3);
        step(4);
        en = 1'b0;
        step(14);
        en = 1'b1;
        check("en_mid_cnt", int'(cnt0), 4);

        // Reset during the second pulse cycle, then an edge right at re-arm.
        lvl0 = 1'b0;
        step(4);
        t = cyc;
        lvl0 = 1'b1; exp_p[0].push_back(t + 3);
        step(4);
        rst_n = 1'b0;
        step(1);
        check("midrst_pulse", int'(pul[0]), 0);
        check("midrst_busy", int'(bsy[0]), 0);
        check("midrst_cnt", int'(cnt0), 0);
        rst_n = 1'b1; lvl0 = 1'b0;
        step(1);
        lvl0 = 1'b1; exp_p[0].push_back(cyc + 3);
        step(3);
        check("rearm_cnt", int'(cnt0), 1);
        step(15);

        // Both edges, width 1, no holdoff: spaced, back-to-back, then a drop.
        for (int i = 0; i < 4; i++) begin
            lvl1 = ~lvl1; exp_p[1].push_back(cyc + 3);
            step(4);
        end
        for (int i = 0; i < 4; i++) begin
            lvl1 = ~lvl1; exp_p[1].push_back(cyc + 3);
            step(2);
        end
        step(4);
        lvl1 = ~lvl1; exp_p[1].push_back(cyc + 3);
        step(1);
        lvl1 = ~lvl1; exp_d[1].push_back(cyc + 3);
        step(8);
        check("both_edge_cnt", int'(cnt1), 9);

        // Falling-only with a 2-bit counter: 5 launches wrap to 1.
        for (int i = 0; i < 10; i++) begin
            lvl2 = ~lvl2;
            if (lvl2 == 1'b0) exp_p[2].push_back(cyc + 3);
            step(4);
        end
        step(4);
        check("fall_cnt_wrap", int'(cnt2), 1);
        check("u0_cnt_untouched", int'(cnt0), 1);

        step(5);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pending_pulses%0d", i), exp_p[i].size(), 0);
            check($sformatf("pending_drops%0d", i), exp_d[i].size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
